// File: rtl/ifetch_pq_pkg.sv
// Shared constants and the queue entry layout for the prefetching fetch unit.
package ifetch_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]             inst;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_pq_fetch_fifo.sv
// Synchronous FIFO with flush; head data is read straight from storage.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_pq.sv
// Prefetching instruction fetch with credit-limited requests and redirect flush.
// Define IFETCH_PQ_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module ifetch_pq
  import ifetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam int              EW        = 32 + 2 * XLEN;
  localparam logic [XLEN-1:0] STEP      = XLEN'(PC_STEP);
  localparam logic [CW:0]     DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUT);

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_out_next;
  logic [EW-1:0]   w_head;
  logic            w_empty;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_byp;
  logic            w_byp_take;
  logic            w_push;
  logic            w_pop;

  // Queued plus in-flight never exceeds DEPTH, so every kept response has a slot.
  assign mem_req_valid = rst && (r_outstanding < MAX_OUT_C) &&
                         (({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_C);
  assign mem_req_addr  = r_fpc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_rsp_keep    = mem_rsp_valid && (r_drop == '0);
  assign w_out_next    = r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_valid);

`ifdef IFETCH_PQ_BYPASS_EN
  assign w_byp = w_empty && w_rsp_keep && !redirect_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_take = w_byp && out_ready;
  assign w_push     = w_rsp_keep && !redirect_valid && !w_byp_take;
  assign w_pop      = !w_empty && out_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  ({mem_rsp_data, r_rpc, r_rpc + STEP}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_comb begin
    out_valid                   = !w_empty || w_byp;
    {out_inst, out_pc, out_pc4} = {32'h0, RESET_PC, RESET_PC + STEP};
    if (w_byp) begin
      {out_inst, out_pc, out_pc4} = {mem_rsp_data, r_rpc, r_rpc + STEP};
    end else if (!w_empty) begin
      {out_inst, out_pc, out_pc4} = w_head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc         <= RESET_PC;
      r_rpc         <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fpc  <= redirect_pc;
        r_rpc  <= redirect_pc;
        r_drop <= w_out_next;
      end else begin
        if (w_req_fire) r_fpc <= r_fpc + STEP;
        if (w_rsp_keep) r_rpc <= r_rpc + STEP;
        else if (mem_rsp_valid) r_drop <= r_drop - CW'(1);
      end
    end
  end

endmodule
